// File: rtl/vga_timing_pkg.sv
// Shared raster geometry types, standard presets and total-length helper.
package vga_timing_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] front;
    logic [15:0] sync;
    logic [15:0] back;
  } axis_geom_t;

  typedef struct packed {
    axis_geom_t h;
    axis_geom_t v;
  } timing_geom_t;

  localparam timing_geom_t VGA_640x480_60 = '{
    h: '{active: 16'd640, front: 16'd16, sync: 16'd96, back: 16'd48},
    v: '{active: 16'd480, front: 16'd10, sync: 16'd2,  back: 16'd33}
  };

  localparam timing_geom_t SYS86_288x224 = '{
    h: '{active: 16'd288, front: 16'd24, sync: 16'd32, back: 16'd40},
    v: '{active: 16'd224, front: 16'd16, sync: 16'd8,  back: 16'd16}
  };

  function automatic int axis_total(axis_geom_t g);
    return int'(g.active) + int'(g.front) + int'(g.sync) + int'(g.back);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with active-region and sync-window decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter axis_geom_t GEOM = VGA_640x480_60.h,
  parameter int         W    = 11
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync_on
);

  localparam int TOTAL      = axis_total(GEOM);
  localparam int SYNC_START = int'(GEOM.active) + int'(GEOM.front);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(int'(GEOM.active));
  localparam logic [W-1:0] SYNC_LO = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_HI = W'(SYNC_START + int'(GEOM.sync));

  logic [W-1:0] cnt_q, cnt_d;

  // wrap is qualified by adv so it can directly enable the next axis
  assign wrap    = adv && (cnt_q == LAST);
  assign active  = cnt_q < ACT_END;
  assign sync_on = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wrap)     cnt_d = '0;
    else if (adv) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing source: sync, output enable, coordinates and frame_start.
// Define VGA_TIMING_LINE_REQ_EN to add the early line-request strobe.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int C_H_ACTIVE       = 640,
  parameter int C_H_FRONT        = 16,
  parameter int C_H_SYNC         = 96,
  parameter int C_H_BACK         = 48,
  parameter int C_V_ACTIVE       = 480,
  parameter int C_V_FRONT        = 10,
  parameter int C_V_SYNC         = 2,
  parameter int C_V_BACK         = 33,
  parameter bit C_HSYNC_POLARITY = 1'b0,
  parameter bit C_VSYNC_POLARITY = 1'b0,
  parameter int C_COORD_WIDTH    = 11,
  parameter int C_LINE_REQ_LEAD  = 32
) (
  input  logic                     pixel_clk,
  input  logic                     reset_n,
  input  logic                     pixel_en,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     output_enable,
  output logic [C_COORD_WIDTH-1:0] x,
  output logic [C_COORD_WIDTH-1:0] y,
  output logic                     frame_start,
  output logic                     line_req,
  output logic [C_COORD_WIDTH-1:0] line_req_y
);

  localparam int W = C_COORD_WIDTH;

  localparam axis_geom_t H_GEOM = '{active: 16'(C_H_ACTIVE), front: 16'(C_H_FRONT),
                                    sync: 16'(C_H_SYNC), back: 16'(C_H_BACK)};
  localparam axis_geom_t V_GEOM = '{active: 16'(C_V_ACTIVE), front: 16'(C_V_FRONT),
                                    sync: 16'(C_V_SYNC), back: 16'(C_V_BACK)};
  localparam int H_TOTAL = axis_total(H_GEOM);
  localparam int V_TOTAL = axis_total(V_GEOM);

  if (H_TOTAL >= (1 << W) || V_TOTAL >= (1 << W)) begin : g_geom_err
    $error("vga_timing_generator: raster totals do not fit in C_COORD_WIDTH");
  end
  if (C_LINE_REQ_LEAD < 1 || C_LINE_REQ_LEAD > H_TOTAL - 1) begin : g_lead_err
    $error("vga_timing_generator: C_LINE_REQ_LEAD out of range 1..H_TOTAL-1");
  end

  logic [W-1:0] h_cnt, v_cnt;
  logic         h_wrap, h_act, h_sync, v_act, v_sync, unused_v_wrap;

  vga_axis_counter #(.GEOM(H_GEOM), .W(W)) u_h_axis (
    .gclk(pixel_clk), .grst_n(reset_n), .adv(pixel_en),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync_on(h_sync)
  );

  vga_axis_counter #(.GEOM(V_GEOM), .W(W)) u_v_axis (
    .gclk(pixel_clk), .grst_n(reset_n), .adv(h_wrap),
    .cnt(v_cnt), .wrap(unused_v_wrap), .active(v_act), .sync_on(v_sync)
  );

  logic         hsync_q, hsync_d, vsync_q, vsync_d, oe_q, oe_d, fs_q, fs_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;

  // Everything holds while pixel_en is low, including the frame_start pulse.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    oe_d    = oe_q;
    x_d     = x_q;
    y_d     = y_q;
    fs_d    = fs_q;
    if (pixel_en) begin
      hsync_d = h_sync ? C_HSYNC_POLARITY : ~C_HSYNC_POLARITY;
      vsync_d = v_sync ? C_VSYNC_POLARITY : ~C_VSYNC_POLARITY;
      oe_d    = h_act && v_act;
      x_d     = oe_d ? h_cnt : '0;
      y_d     = oe_d ? v_cnt : '0;
      fs_d    = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q <= ~C_HSYNC_POLARITY;
      vsync_q <= ~C_VSYNC_POLARITY;
      oe_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      oe_q    <= oe_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign output_enable = oe_q;
  assign x             = x_q;
  assign y             = y_q;
  assign frame_start   = fs_q;

`ifdef VGA_TIMING_LINE_REQ_EN
  localparam logic [W-1:0] REQ_H  = W'(H_TOTAL - C_LINE_REQ_LEAD);
  localparam logic [W-1:0] V_LAST = W'(V_TOTAL - 1);
  localparam logic [W-1:0] V_ACT  = W'(C_V_ACTIVE);

  logic         lr_q, lr_d;
  logic [W-1:0] lry_q, lry_d, next_v;

  // Request the line that follows the current one, skipping blanking lines.
  always_comb begin
    next_v = (v_cnt == V_LAST) ? '0 : v_cnt + W'(1);
    lr_d   = lr_q;
    lry_d  = lry_q;
    if (pixel_en) begin
      lr_d = (h_cnt == REQ_H) && (next_v < V_ACT);
      if (lr_d) lry_d = next_v;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      lr_q  <= 1'b0;
      lry_q <= '0;
    end else begin
      lr_q  <= lr_d;
      lry_q <= lry_d;
    end
  end

  assign line_req   = lr_q;
  assign line_req_y = lry_q;
`else
  assign line_req   = 1'b0;
  assign line_req_y = '0;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed scoreboard bench on a 12x7 raster, default and inverted sync polarity.
module tb_vga_timing_generator;

  logic        pixel_clk = 1'b0;
  logic        reset_n   = 1'b1;
  logic        pixel_en  = 1'b0;

  logic        hsync, vsync, oe, fs, lr;
  logic [10:0] x, y, lry;
  logic        hsync_i, vsync_i, oe_i, fs_i, lr_i;
  logic [10:0] x_i, y_i, lry_i;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_generator #(
    .C_H_ACTIVE(8), .C_H_FRONT(1), .C_H_SYNC(2), .C_H_BACK(1),
    .C_V_ACTIVE(4), .C_V_FRONT(1), .C_V_SYNC(1), .C_V_BACK(1),
    .C_HSYNC_POLARITY(1'b0), .C_VSYNC_POLARITY(1'b0),
    .C_COORD_WIDTH(11), .C_LINE_REQ_LEAD(3)
  ) dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .pixel_en(pixel_en),
    .hsync(hsync), .vsync(vsync), .output_enable(oe), .x(x), .y(y),
    .frame_start(fs), .line_req(lr), .line_req_y(lry)
  );

  vga_timing_generator #(
    .C_H_ACTIVE(8), .C_H_FRONT(1), .C_H_SYNC(2), .C_H_BACK(1),
    .C_V_ACTIVE(4), .C_V_FRONT(1), .C_V_SYNC(1), .C_V_BACK(1),
    .C_HSYNC_POLARITY(1'b1), .C_VSYNC_POLARITY(1'b1),
    .C_COORD_WIDTH(11), .C_LINE_REQ_LEAD(3)
  ) dut_inv (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .pixel_en(pixel_en),
    .hsync(hsync_i), .vsync(vsync_i), .output_enable(oe_i), .x(x_i), .y(y_i),
    .frame_start(fs_i), .line_req(lr_i), .line_req_y(lry_i)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        oe;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic        lr;
    logic [10:0] lry;
  } exp_t;

  localparam exp_t RST_EXP = '{hs: 1'b1, vs: 1'b1, oe: 1'b0, x: 11'd0, y: 11'd0,
                               fs: 1'b0, lr: 1'b0, lry: 11'd0};

  exp_t cur;
  exp_t sb[$];
  int   mh, mv;
  int   total = 0, bad = 0;
  int   clk_n = 0, fs_clk = 0, period = 0;
  bit   fs_seen = 0;
  logic fs_prev = 1'b0;
  int   n_oe, n_vs, n_fs, n_lr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode of raster position (h, v) straight from the geometry.
  function automatic exp_t decode(input int h, input int v, input logic [10:0] prev_lry);
    exp_t e;
    int   nv;
    e.hs  = !(h >= 9 && h <= 10);
    e.vs  = !(v == 5);
    e.oe  = (h < 8) && (v < 4);
    e.x   = e.oe ? 11'(h) : 11'd0;
    e.y   = e.oe ? 11'(v) : 11'd0;
    e.fs  = (h == 0) && (v == 0);
    nv    = (v + 1) % 7;
`ifdef VGA_TIMING_LINE_REQ_EN
    e.lr  = (h == 9) && (nv < 4);
    e.lry = e.lr ? 11'(nv) : prev_lry;
`else
    e.lr  = 1'b0;
    e.lry = 11'd0 & prev_lry;
`endif
    return e;
  endfunction

  task automatic check_all(input string phase, input exp_t e);
    logic ih, iv;
    ih = ~e.hs;
    iv = ~e.vs;
    chk({phase, ".hsync"}, 32'(hsync), 32'(e.hs));
    chk({phase, ".vsync"}, 32'(vsync), 32'(e.vs));
    chk({phase, ".oe"},    32'(oe),    32'(e.oe));
    chk({phase, ".x"},     32'(x),     32'(e.x));
    chk({phase, ".y"},     32'(y),     32'(e.y));
    chk({phase, ".fs"},    32'(fs),    32'(e.fs));
    chk({phase, ".lr"},    32'(lr),    32'(e.lr));
    chk({phase, ".lry"},   32'(lry),   32'(e.lry));
    chk({phase, ".inv_hsync"}, 32'(hsync_i), 32'(ih));
    chk({phase, ".inv_vsync"}, 32'(vsync_i), 32'(iv));
    chk({phase, ".inv_oe"},    32'(oe_i),    32'(e.oe));
    chk({phase, ".inv_x"},     32'(x_i),     32'(e.x));
    chk({phase, ".inv_y"},     32'(y_i),     32'(e.y));
    chk({phase, ".inv_fs"},    32'(fs_i),    32'(e.fs));
  endtask

  task automatic model_reset();
    cur = RST_EXP;
    mh  = 0;
    mv  = 0;
  endtask

  // One clock: drive enable, push the model's prediction, compare after the edge.
  task automatic step(input bit en);
    exp_t e;
    @(negedge pixel_clk);
    pixel_en = en;
    if (en) begin
      cur = decode(mh, mv, cur.lry);
      mh++;
      if (mh == 12) begin
        mh = 0;
        mv = (mv + 1) % 7;
      end
    end
    sb.push_back(cur);
    @(posedge pixel_clk);
    #1;
    e = sb.pop_front();
    check_all("run", e);
    clk_n++;
    if (oe)      n_oe++;
    if (!vsync)  n_vs++;
    if (fs)      n_fs++;
    if (lr)      n_lr++;
    if (fs && !fs_prev) begin
      if (fs_seen) period = clk_n - fs_clk;
      fs_clk  = clk_n;
      fs_seen = 1;
    end
    fs_prev = fs;
  endtask

  initial begin
    int guard;
    model_reset();
    #1 reset_n = 1'b0;
    #1 check_all("reset_async", RST_EXP);
    repeat (2) @(posedge pixel_clk);
    #1 check_all("reset_held", RST_EXP);
    @(negedge pixel_clk);
    reset_n = 1'b1;

    // Continuous enable: first line, first frame, then a second frame.
    n_oe = 0; n_vs = 0; n_fs = 0; n_lr = 0;
    repeat (12) step(1'b1);
    chk("line_oe_cycles", 32'(n_oe), 32'd8);
    repeat (72) step(1'b1);
    chk("frame_vsync_cycles", 32'(n_vs), 32'd12);
    chk("frame_fs_cycles", 32'(n_fs), 32'd1);
`ifdef VGA_TIMING_LINE_REQ_EN
    chk("frame_line_req_pulses", 32'(n_lr), 32'd4);
`else
    chk("frame_line_req_pulses", 32'(n_lr), 32'd0);
`endif
    repeat (84) step(1'b1);
    chk("frame_period_en1", 32'(period), 32'd84);

    // Alternating enable: frame period doubles, pulse spans two clocks.
    n_fs = 0;
    repeat (84) begin
      step(1'b1);
      step(1'b0);
    end
    chk("toggle_fs_clocks", 32'(n_fs), 32'd2);
    repeat (2) begin
      step(1'b1);
      step(1'b0);
    end
    chk("frame_period_toggle", 32'(period), 32'd168);

    // Run to h_cnt=5, v_cnt=2, then reset between clock edges.
    guard = 0;
    while (!(mh == 5 && mv == 2) && guard < 100) begin
      step(1'b1);
      guard++;
    end
    chk("reach_midline", 32'(guard < 100), 32'd1);
    #2;
    reset_n  = 1'b0;
    pixel_en = 1'b0;
    #1 check_all("reset_midline", RST_EXP);
    model_reset();
    fs_prev = 1'b0;
    @(negedge pixel_clk);
    reset_n = 1'b1;
    step(1'b1);
    chk("post_reset_x", 32'(x), 32'd0);
    chk("post_reset_y", 32'(y), 32'd0);
    chk("post_reset_fs", 32'(fs), 32'd1);
    repeat (40) step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
